// File: rtl/gshare_pattern_history_table_pkg.sv
// Shared types and helpers for the gshare pattern history table.
// Optional feature macro: GSHARE_PHT_HASH_EN (see the top-level file).
package gshare_pkg;

  // Table controller states: the reset-time sweep and normal operation.
  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Instructions are word aligned, so the two lowest PC bits carry no information.
  localparam int unsigned PC_IDX_OFFSET = 2;

  // Reset value of a counter: even entries start weakly taken, odd entries weakly
  // not-taken, so a freshly initialised table has no bias either way.
  function automatic logic [31:0] init_counter_value(input logic odd, input int unsigned width);
    logic [31:0] weak_taken;
    weak_taken = 32'd1 << (width - 1);
    return odd ? (weak_taken - 32'd1) : weak_taken;
  endfunction

endpackage

// File: rtl/gshare_pattern_history_table_if.sv
// Fetch/resolution bundle of the gshare pattern history table.
// master = pipeline side (fetch + branch resolution), slave = the predictor.
interface gshare_pattern_history_table_if #(
  parameter int S_INDEX  = 10,
  parameter int HIST_LEN = 10
);
  logic                ready;
  logic                predict_valid;
  logic [31:0]         predict_pc;
  logic                predict_taken;
  logic [S_INDEX-1:0]  predict_index;
  logic [HIST_LEN-1:0] predict_hist;
  logic                update_valid;
  logic [S_INDEX-1:0]  update_index;
  logic [HIST_LEN-1:0] update_hist;
  logic                update_taken;
  logic                update_mispredict;

  modport master (
    input  ready, predict_taken, predict_index, predict_hist,
    output predict_valid, predict_pc,
    output update_valid, update_index, update_hist, update_taken, update_mispredict
  );

  modport slave (
    output ready, predict_taken, predict_index, predict_hist,
    input  predict_valid, predict_pc,
    input  update_valid, update_index, update_hist, update_taken, update_mispredict
  );
endinterface

// File: rtl/gshare_pattern_history_table_sat_counter_step.sv
// One step of a WIDTH-bit saturating counter: up_i=1 counts up, up_i=0 counts down.
module sat_counter_step #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] cnt_o
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // Move one step toward the outcome, holding at either end of the range.
  always_comb begin
    cnt_o = cnt_i;
    if (up_i) begin
      if (cnt_i != CNT_MAX) cnt_o = cnt_i + WIDTH'(1);
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - WIDTH'(1);
    end
  end
endmodule

// File: rtl/gshare_pattern_history_table.sv
// gshare branch-direction predictor: 2**S_INDEX saturating counters indexed by
// PC ^ speculative global history, trained by resolved outcomes, with history
// restore on mispredict and a self-sequenced table sweep after reset.
// Macro GSHARE_PHT_HASH_EN: defined -> PC/history hash; undefined -> bimodal
// indexing by PC only (history is still tracked and reported).
module gshare_pattern_history_table
  import gshare_pkg::*;
#(
  parameter int S_INDEX  = 10,
  parameter int WIDTH    = 2,
  parameter int HIST_LEN = 10
) (
  input logic                          clk,
  input logic                          rst_n,
  gshare_pattern_history_table_if.slave bus
);
  localparam int unsigned        ENTRIES    = 1 << S_INDEX;
  localparam logic [S_INDEX-1:0] LAST_ENTRY = '1;

  logic [WIDTH-1:0] pht_mem [ENTRIES];

  state_e              state_q, state_d;
  logic [S_INDEX-1:0]  init_ptr_q, init_ptr_d;
  logic [HIST_LEN-1:0] ghr_q, ghr_d;

  logic                is_ready;
  logic [S_INDEX-1:0]  pc_index;
  logic [S_INDEX-1:0]  hist_index;
  logic [S_INDEX-1:0]  pred_index;
  logic [WIDTH-1:0]    upd_old;
  logic [WIDTH-1:0]    upd_new;
  logic [WIDTH-1:0]    pred_cnt;
  logic                upd_en;
  logic                bypass_hit;
  logic [HIST_LEN-1:0] shift_hist;
  logic [HIST_LEN-1:0] restore_hist;
  logic [WIDTH-1:0]    init_value;

  assign is_ready = (state_q == READY);
  assign pc_index = bus.predict_pc[PC_IDX_OFFSET +: S_INDEX];

`ifdef GSHARE_PHT_HASH_EN
  assign hist_index = S_INDEX'(ghr_q);
`else
  assign hist_index = '0;
`endif

  assign pred_index = pc_index ^ hist_index;

  // Training is ignored while the sweep owns the write port.
  assign upd_en  = bus.update_valid && is_ready;
  assign upd_old = pht_mem[bus.update_index];

  sat_counter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cnt_i (upd_old),
    .up_i  (bus.update_taken),
    .cnt_o (upd_new)
  );

  // A same-cycle update to the predicted entry is forwarded so fetch never sees a stale counter.
  assign bypass_hit = upd_en && (bus.update_index == pred_index);
  assign pred_cnt   = bypass_hit ? upd_new : pht_mem[pred_index];

  assign bus.predict_taken = is_ready && pred_cnt[WIDTH-1];
  assign bus.predict_index = pred_index;
  assign bus.predict_hist  = ghr_q;
  assign bus.ready         = is_ready;

  assign init_value = WIDTH'(init_counter_value(init_ptr_q[0], WIDTH));

  // With a single history bit the shift degenerates into a plain load.
  generate
    if (HIST_LEN == 1) begin : g_hist_load
      assign shift_hist   = bus.predict_taken;
      assign restore_hist = bus.update_taken;
    end else begin : g_hist_shift
      assign shift_hist   = {ghr_q[HIST_LEN-2:0], bus.predict_taken};
      assign restore_hist = {bus.update_hist[HIST_LEN-2:0], bus.update_taken};
    end
  endgenerate

  // Next state: sweep pointer in INIT; history restore beats speculative shift in READY.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    if (state_q == INIT) begin
      init_ptr_d = init_ptr_q + S_INDEX'(1);
      if (init_ptr_q == LAST_ENTRY) state_d = READY;
    end else begin
      if (bus.update_valid && bus.update_mispredict) begin
        ghr_d = restore_hist;
      end else if (bus.predict_valid) begin
        ghr_d = shift_hist;
      end
    end
  end

  // Control state; reset restarts the sweep and clears history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
    end
  end

  // Counter array is not reset; the sweep writes one entry per cycle, then training takes over.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      pht_mem[init_ptr_q] <= init_value;
    end else if (bus.update_valid) begin
      pht_mem[bus.update_index] <= upd_new;
    end
  end

endmodule
